multicycle_control: RTL and testbench

// - Multicycle successor to the single-cycle decoder: FSM sequencing each instruction over

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/mc_opcode_decode.sv | 27 ++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control unit:
// FSM state enum, opcode values, ALUSrcB codes and the opcode class bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        JUMP
    } state_t;

    localparam logic [5:0] OP_AND  = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_NOR  = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_NOT  = 6'b000100;
    localparam logic [5:0] OP_BLEU = 6'b010000;
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;

    localparam logic [1:0] ALUSRCB_REG  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

    localparam logic [4:0] ALU_ADD = 5'b11111;

    // One-hot instruction class; all zero means undecodable.
    typedef struct packed {
        logic ld;
        logic st;
        logic rtype;
        logic itype;
        logic branch;
        logic jr;
        logic jal;
    } op_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: maps the 6-bit opcode onto a one-hot
// class bundle. Ports: opcode in; cls (one-hot class), illegal out.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls,
    output logic       illegal
);

    always_comb begin
        cls     = '0;
        illegal = 1'b0;
        unique case (opcode)
            OP_AND, OP_NOR, OP_NOT,
            OP_ROLV, OP_RORV: cls.rtype  = 1'b1;
            OP_NORI:          cls.itype  = 1'b1;
            OP_LW:            cls.ld     = 1'b1;
            OP_SW:            cls.st     = 1'b1;
            OP_BLEU:          cls.branch = 1'b1;
            OP_JR:            cls.jr     = 1'b1;
            OP_JAL:           cls.jal    = 1'b1;
            default:          illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// MEM_LAT-cycle memory accesses, run gating and a sticky illegal-opcode flag.
// Ports: clock, reset (sync, high), run, ins in; datapath selects/enables,
// ALUControl, illegal and state (debug) out.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int INS_W   = 32,
    parameter int ALU_W   = 5,
    parameter int MEM_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [INS_W-1:0] ins,
    output logic             PCWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [ALU_W-1:0] ALUControl,
    output logic             memToReg,
    output logic             memWrite,
    output logic             branchEnable,
    output logic             regDst,
    output logic             regWriteEnable,
    output logic             jump,
    output logic             jumpReg,
    output logic             illegal,
    output logic [3:0]       state
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [ALU_W-1:0] ADD_OP = ALU_W'(ALU_ADD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic [5:0]       opcode;
    logic [ALU_W-1:0] alu_f;
    op_class_t        cls;
    logic             op_ill;
    logic             last;
    logic             unused_ins;

    assign opcode     = ins[INS_W-1 -: 6];
    assign alu_f      = ins[INS_W-1 -: ALU_W];
    assign unused_ins = ^ins[INS_W-7:0];
    assign last       = (cnt_q == CNT_LAST);

    mc_opcode_decode u_dec (
        .opcode  (opcode),
        .cls     (cls),
        .illegal (op_ill)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    // Counter only advances in memory states; it wraps to 0 on the
    // final access cycle so the next access starts clean.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        if (run) begin
            unique case (state_q)
                FETCH: begin
                    if (last) begin
                        state_d = DECODE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DECODE: begin
                    if (op_ill) begin
                        state_d = FETCH;
                        ill_d   = 1'b1;
                    end else begin
                        unique case (1'b1)
                            cls.ld, cls.st:
                                state_d = MEMADR;
                            cls.rtype, cls.itype:
                                state_d = EXEC;
                            cls.branch:
                                state_d = BRANCH;
                            cls.jr, cls.jal:
                                state_d = JUMP;
                            default:
                                state_d = FETCH;
                        endcase
                    end
                end
                MEMADR: state_d = cls.ld ? MEMRD : MEMWR;
                MEMRD, MEMWR: begin
                    if (last) begin
                        state_d = (state_q == MEMRD)
                                ? MEMWB : FETCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                EXEC:   state_d = ALUWB;
                ALUWB, MEMWB,
                BRANCH, JUMP: state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Moore output decode; everything is held at 0 while reset is high.
    always_comb begin
        PCWrite        = 1'b0;
        IorD           = 1'b0;
        IRWrite        = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = ALUSRCB_REG;
        ALUControl     = '0;
        memToReg       = 1'b0;
        memWrite       = 1'b0;
        branchEnable   = 1'b0;
        regDst         = 1'b0;
        regWriteEnable = 1'b0;
        jump           = 1'b0;
        jumpReg        = 1'b0;
        illegal        = 1'b0;
        state          = '0;
        if (!reset) begin
            state   = state_q;
            illegal = ill_q;
            unique case (state_q)
                FETCH: begin
                    ALUSrcB    = ALUSRCB_FOUR;
                    ALUControl = ADD_OP;
                    IRWrite    = last;
                    PCWrite    = last;
                end
                DECODE: ALUControl = alu_f;
                MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = ALUSRCB_IMM;
                    ALUControl = ADD_OP;
                end
                MEMRD: IorD = 1'b1;
                MEMWB: begin
                    memToReg       = 1'b1;
                    regWriteEnable = 1'b1;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    memWrite = last;
                end
                EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = cls.itype ? ALUSRCB_IMM
                                           : ALUSRCB_REG;
                    ALUControl = alu_f;
                end
                ALUWB: begin
                    regWriteEnable = 1'b1;
                    regDst         = cls.rtype;
                end
                BRANCH: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = ALUSRCB_REG;
                    ALUControl   = alu_f;
                    branchEnable = 1'b1;
                end
                JUMP: begin
                    jump           = 1'b1;
                    jumpReg        = cls.jr;
                    regWriteEnable = cls.jal;
                end
                default: ;
            endcase
            // Stalled cycles must not commit anything.
            if (!run) begin
                PCWrite        = 1'b0;
                IRWrite        = 1'b0;
                memWrite       = 1'b0;
                regWriteEnable = 1'b0;
                branchEnable   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: two instances (MEM_LAT 1, 3)
// checked cycle by cycle against a per-instruction step-list model.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       iord;
        logic       irw;
        logic       srca;
        logic [1:0] srcb;
        logic [4:0] aluc;
        logic       m2r;
        logic       mw;
        logic       be;
        logic       rd;
        logic       rwe;
        logic       j;
        logic       jr;
        logic       ill;
    } outs_t;

    typedef struct {
        int cycles;
        int irw_at;
        int irw_cnt;
        int m2r_at;
        int mw_cnt;
        int mw_at;
        int rwe_cnt;
    } stats_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int lat [2] = '{1, 3};
    int n_chk  = 0;
    int n_fail = 0;
    bit ill_exp [2];

    logic        rst_v [2];
    logic        run_v [2];
    logic [31:0] ins_v [2];

    logic       pcw [2], iord [2], irw [2], srca [2];
    logic       m2r [2], mw [2], be [2], rd [2];
    logic       rwe [2], jmp [2], jr [2], ill [2];
    logic [1:0] srcb [2];
    logic [4:0] aluc [2];
    logic [3:0] st [2];

    multicycle_control #(
        .INS_W(32), .ALU_W(5), .MEM_LAT(1)
    ) u_lat1 (
        .clock(clk), .reset(rst_v[0]),
        .run(run_v[0]), .ins(ins_v[0]),
        .PCWrite(pcw[0]), .IorD(iord[0]),
        .IRWrite(irw[0]), .ALUSrcA(srca[0]),
        .ALUSrcB(srcb[0]), .ALUControl(aluc[0]),
        .memToReg(m2r[0]), .memWrite(mw[0]),
        .branchEnable(be[0]), .regDst(rd[0]),
        .regWriteEnable(rwe[0]), .jump(jmp[0]),
        .jumpReg(jr[0]), .illegal(ill[0]),
        .state(st[0])
    );

    multicycle_control #(
        .INS_W(32), .ALU_W(5), .MEM_LAT(3)
    ) u_lat3 (
        .clock(clk), .reset(rst_v[1]),
        .run(run_v[1]), .ins(ins_v[1]),
        .PCWrite(pcw[1]), .IorD(iord[1]),
        .IRWrite(irw[1]), .ALUSrcA(srca[1]),
        .ALUSrcB(srcb[1]), .ALUControl(aluc[1]),
        .memToReg(m2r[1]), .memWrite(mw[1]),
        .branchEnable(be[1]), .regDst(rd[1]),
        .regWriteEnable(rwe[1]), .jump(jmp[1]),
        .jumpReg(jr[1]), .illegal(ill[1]),
        .state(st[1])
    );

    function automatic outs_t get_obs(input int d);
        outs_t o;
        o.st   = st[d];
        o.pcw  = pcw[d];
        o.iord = iord[d];
        o.irw  = irw[d];
        o.srca = srca[d];
        o.srcb = srcb[d];
        o.aluc = aluc[d];
        o.m2r  = m2r[d];
        o.mw   = mw[d];
        o.be   = be[d];
        o.rd   = rd[d];
        o.rwe  = rwe[d];
        o.j    = jmp[d];
        o.jr   = jr[d];
        o.ill  = ill[d];
        return o;
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'b100000, 6'b100011, 6'b101011,
                          6'b001000, 6'b000011, 6'b100110,
                          6'b001110, 6'b000100, 6'b010000,
                          6'b000000, 6'b000010};
    endfunction

    // Expected per-cycle outputs of one instruction at run=1.
    outs_t plan [$];

    task automatic build_plan(input logic [31:0] i, input int L);
        logic [5:0] op;
        logic [4:0] f;
        outs_t s;
        op = i[31:26];
        f  = i[31:27];
        plan.delete();
        for (int k = 0; k < L; k++) begin
            s = '0; s.st = FETCH; s.srcb = 2'b01; s.aluc = 5'h1f;
            s.irw = (k == L - 1); s.pcw = (k == L - 1);
            plan.push_back(s);
        end
        s = '0; s.st = DECODE; s.aluc = f;
        plan.push_back(s);
        case (op)
            6'b100011, 6'b101011: begin
                s = '0; s.st = MEMADR; s.srca = 1'b1;
                s.srcb = 2'b10; s.aluc = 5'h1f;
                plan.push_back(s);
                for (int k = 0; k < L; k++) begin
                    s = '0; s.iord = 1'b1;
                    s.st = (op == 6'b100011) ? MEMRD : MEMWR;
                    s.mw = (op == 6'b101011) && (k == L - 1);
                    plan.push_back(s);
                end
                if (op == 6'b100011) begin
                    s = '0; s.st = MEMWB; s.m2r = 1'b1; s.rwe = 1'b1;
                    plan.push_back(s);
                end
            end
            6'b100000, 6'b100110, 6'b000100,
            6'b000000, 6'b000010, 6'b001110: begin
                s = '0; s.st = EXEC; s.srca = 1'b1; s.aluc = f;
                s.srcb = (op == 6'b001110) ? 2'b10 : 2'b00;
                plan.push_back(s);
                s = '0; s.st = ALUWB; s.rwe = 1'b1;
                s.rd = (op != 6'b001110);
                plan.push_back(s);
            end
            6'b010000: begin
                s = '0; s.st = BRANCH; s.srca = 1'b1;
                s.aluc = f; s.be = 1'b1;
                plan.push_back(s);
            end
            6'b001000, 6'b000011: begin
                s = '0; s.st = JUMP; s.j = 1'b1;
                s.jr  = (op == 6'b001000);
                s.rwe = (op == 6'b000011);
                plan.push_back(s);
            end
            default: ;
        endcase
    endtask

    // Runs one instruction (or its first max_steps steps) on dut d.
    task automatic run_instr(input int d, input logic [31:0] i,
                             input int pct, input int stall_at,
                             input int stall_len, input int max_steps,
                             output stats_t s);
        int k, n, extra;
        logic go;
        outs_t want, got;
        build_plan(i, lat[d]);
        n = plan.size();
        if (max_steps > 0 && max_steps < n) n = max_steps;
        s = '{default: 0};
        k = 0;
        extra = 0;
        while (k < n) begin
            @(negedge clk);
            go = 1'b1;
            if (k == stall_at && extra < stall_len) begin
                go = 1'b0;
                extra++;
            end else if (pct > 0 && $urandom_range(99) < pct) begin
                go = 1'b0;
            end
            rst_v[d] = 1'b0;
            run_v[d] = go;
            ins_v[d] = i;
            #1;
            s.cycles++;
            want = plan[k];
            want.ill = ill_exp[d];
            if (!go) begin
                want.pcw = 0; want.irw = 0; want.mw = 0;
                want.rwe = 0; want.be = 0;
            end
            got = get_obs(d);
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL step d%0d ins=%h k=%0d run=%0b got=%h want=%h",
                         d, i, k, go, got, want);
            end
            if (got.irw) begin s.irw_at = s.cycles; s.irw_cnt++; end
            if (got.m2r) s.m2r_at = s.cycles;
            if (got.mw) begin s.mw_at = s.cycles; s.mw_cnt++; end
            if (got.rwe) s.rwe_cnt++;
            if (go) begin
                if (plan[k].st == DECODE && !legal_op(i[31:26]))
                    ill_exp[d] = 1'b1;
                k++;
            end
        end
    endtask

    task automatic do_reset(input int d, input int n);
        outs_t got;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_v[d] = 1'b1;
            run_v[d] = 1'b1;
            ins_v[d] = $urandom;
            #1;
            got = get_obs(d);
            n_chk++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL reset_outs d%0d got=%h want=0", d, got);
            end
        end
        ill_exp[d] = 1'b0;
    endtask

    task automatic test_reset;
        outs_t g0, g1;
        do_reset(0, 3);
        do_reset(1, 3);
        @(negedge clk);
        rst_v[0] = 0; run_v[0] = 1; ins_v[0] = 32'h8000_0000;
        rst_v[1] = 0; run_v[1] = 1; ins_v[1] = 32'h8000_0000;
        #1;
        g0 = get_obs(0);
        g1 = get_obs(1);
        n_chk++;
        if (g0.irw !== 1'b1 || g0.pcw !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch_pulse irw=%b pcw=%b want 1 1",
                     g0.irw, g0.pcw);
        end
        n_chk++;
        if (g0.srcb !== 2'b01 || g0.st !== 4'(FETCH)) begin
            n_fail++;
            $display("FAIL first_fetch_sel srcb=%b st=%0d want 01 0",
                     g0.srcb, g0.st);
        end
        n_chk++;
        if (g1.irw !== 1'b0 || g1.srcb !== 2'b01 || g1.ill !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_first_fetch irw=%b srcb=%b ill=%b want 0 01 0",
                     g1.irw, g1.srcb, g1.ill);
        end
    endtask

    task automatic test_alu;
        stats_t s;
        do_reset(0, 1);
        run_instr(0, 32'h8000_0000, 0, -1, 0, 0, s);
        n_chk++;
        if (s.cycles !== 4 || s.rwe_cnt !== 1) begin
            n_fail++;
            $display("FAIL alu_cpi cycles=%0d rwe=%0d want 4 1",
                     s.cycles, s.rwe_cnt);
        end
        run_instr(0, {6'b001110, 26'($urandom)}, 0, -1, 0, 0, s);
        n_chk++;
        if (s.cycles !== 4) begin
            n_fail++;
            $display("FAIL nori_cpi cycles=%0d want 4", s.cycles);
        end
    endtask

    task automatic test_lw_latency;
        stats_t s;
        do_reset(1, 2);
        run_instr(1, 32'h8C00_0000, 0, -1, 0, 0, s);
        n_chk++;
        if (s.irw_at !== 3 || s.m2r_at !== 9 || s.cycles !== 9) begin
            n_fail++;
            $display("FAIL lw_lat3 irw_at=%0d m2r_at=%0d cyc=%0d want 3 9 9",
                     s.irw_at, s.m2r_at, s.cycles);
        end
    endtask

    task automatic test_sw_stall;
        stats_t s;
        do_reset(1, 1);
        run_instr(1, 32'hAC00_1234, 0, 6, 2, 0, s);
        n_chk++;
        if (s.mw_cnt !== 1 || s.mw_at !== 10 || s.cycles !== 10) begin
            n_fail++;
            $display("FAIL sw_stall mw=%0d at=%0d cyc=%0d want 1 10 10",
                     s.mw_cnt, s.mw_at, s.cycles);
        end
        run_instr(1, 32'hAC00_0000, 0, 1, 3, 0, s);
        n_chk++;
        if (s.irw_cnt !== 1 || s.irw_at !== 6 || s.cycles !== 11) begin
            n_fail++;
            $display("FAIL fetch_stall irw=%0d at=%0d cyc=%0d want 1 6 11",
                     s.irw_cnt, s.irw_at, s.cycles);
        end
    endtask

    task automatic test_jump;
        stats_t s;
        do_reset(0, 1);
        run_instr(0, 32'h0C00_0040, 0, -1, 0, 0, s);
        n_chk++;
        if (s.cycles !== 3 || s.rwe_cnt !== 1) begin
            n_fail++;
            $display("FAIL jal cyc=%0d rwe=%0d want 3 1", s.cycles, s.rwe_cnt);
        end
        run_instr(0, 32'h2000_0000, 0, -1, 0, 0, s);
        n_chk++;
        if (s.cycles !== 3 || s.rwe_cnt !== 0) begin
            n_fail++;
            $display("FAIL jr cyc=%0d rwe=%0d want 3 0", s.cycles, s.rwe_cnt);
        end
        run_instr(0, 32'h4000_0010, 0, -1, 0, 0, s);
        n_chk++;
        if (s.cycles !== 3) begin
            n_fail++;
            $display("FAIL bleu cyc=%0d want 3", s.cycles);
        end
    endtask

    task automatic test_illegal_reset;
        stats_t s;
        outs_t g;
        do_reset(1, 1);
        run_instr(1, 32'hFC00_0000, 0, -1, 0, 0, s);
        @(negedge clk);
        run_v[1] = 1'b0;
        #1;
        g = get_obs(1);
        n_chk++;
        if (g.ill !== 1'b1 || g.st !== 4'(FETCH) || s.cycles !== 4) begin
            n_fail++;
            $display("FAIL illegal_trap ill=%b st=%0d cyc=%0d want 1 0 4",
                     g.ill, g.st, s.cycles);
        end
        // Abandon an LW in its first MEMRD cycle.
        run_instr(1, 32'h8C00_0000, 0, -1, 0, 6, s);
        do_reset(1, 1);
        @(negedge clk);
        rst_v[1] = 1'b0;
        run_v[1] = 1'b0;
        #1;
        g = get_obs(1);
        n_chk++;
        if (g.ill !== 1'b0 || g.st !== 4'(FETCH)) begin
            n_fail++;
            $display("FAIL reset_mid_memrd ill=%b st=%0d want 0 0",
                     g.ill, g.st);
        end
        run_instr(1, 32'h8C00_0000, 0, -1, 0, 0, s);
        n_chk++;
        if (s.irw_at !== 3 || s.cycles !== 9) begin
            n_fail++;
            $display("FAIL after_abort irw_at=%0d cyc=%0d want 3 9",
                     s.irw_at, s.cycles);
        end
    endtask

    logic [5:0] ops [12] = '{6'b100000, 6'b100011, 6'b101011,
                             6'b001000, 6'b000011, 6'b100110,
                             6'b001110, 6'b000100, 6'b010000,
                             6'b000000, 6'b000010, 6'b111111};

    task automatic test_back_to_back;
        stats_t s;
        logic [5:0] op;
        for (int d = 0; d < 2; d++) begin
            do_reset(d, 1);
            for (int n = 0; n < 40; n++) begin
                op = ops[$urandom_range(11)];
                if ($urandom_range(9) == 0) op = 6'($urandom);
                run_instr(d, {op, 26'($urandom)}, 25, -1, 0, 0, s);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;
            run_v[d] = 1'b0;
            ins_v[d] = '0;
            ill_exp[d] = 1'b0;
        end
        test_reset();
        test_alu();
        test_lw_latency();
        test_sw_stall();
        test_jump();
        test_illegal_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
